// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl
// Purpose  : Machine-mode trap sequencer behind write-back. Accepts pending
//            interrupts at the WBU instruction, and detects committed ecall
//            and mret. It then flushes the pipeline, writes mepc/mcause/mstatus
//            through the shared CSR port, and issues one fetch redirect.
//            Only one trap or return is in flight at a time.
// Ports    : i_clk/i_rst          clock, async active-high reset
//            i_wbu_*              WBU instruction state and CSR write request
//            i_intr_pend/code     gated interrupt request and cause code
//            i_csr_*              current mstatus/mtvec/mepc values
//            o_iru_intr           interrupt accepted this cycle (comb)
//            o_flush/o_busy       sequence in progress
//            o_redirect_*         one-cycle fetch redirect
//            o_csr_*              shared CSR write port
// Revision : 1.0 - initial release
// ============================================================================
module trap_ctrl #(
    parameter int CPU_WIDTH = 64,
    parameter int CSR_ADDRW = 12
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_wbu_valid,
    input  logic                 i_wbu_commit,
    input  logic [CPU_WIDTH-1:0] i_wbu_pc,
    input  logic                 i_wbu_ecall,
    input  logic                 i_wbu_mret,
    input  logic                 i_wbu_nop,
    input  logic                 i_wbu_csrdwen,
    input  logic [CSR_ADDRW-1:0] i_wbu_csrdid,
    input  logic [CPU_WIDTH-1:0] i_wbu_csrd,
    input  logic                 i_intr_pend,
    input  logic [3:0]           i_intr_code,
    input  logic [CPU_WIDTH-1:0] i_csr_mstatus,
    input  logic [CPU_WIDTH-1:0] i_csr_mtvec,
    input  logic [CPU_WIDTH-1:0] i_csr_mepc,
    output logic                 o_iru_intr,
    output logic                 o_flush,
    output logic                 o_busy,
    output logic                 o_redirect_valid,
    output logic [CPU_WIDTH-1:0] o_redirect_pc,
    output logic                 o_csr_wen,
    output logic [CSR_ADDRW-1:0] o_csr_waddr,
    output logic [CPU_WIDTH-1:0] o_csr_wdata
);

    localparam logic [CSR_ADDRW-1:0] C_ADDR_MSTATUS = CSR_ADDRW'('h300);
    localparam logic [CSR_ADDRW-1:0] C_ADDR_MEPC    = CSR_ADDRW'('h341);
    localparam logic [CSR_ADDRW-1:0] C_ADDR_MCAUSE  = CSR_ADDRW'('h342);
    localparam logic [CPU_WIDTH-1:0] C_CAUSE_ECALL  = CPU_WIDTH'(11);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_W_MEPC    = 3'd1,
        S_W_MCAUSE  = 3'd2,
        S_W_MSTATUS = 3'd3,
        S_REDIRECT  = 3'd4
    } state_t;

    state_t                 r_state;
    logic                   r_ret;      // 1: mret sequence, 0: trap sequence
    logic [CPU_WIDTH-1:0]   r_epc;
    logic [CPU_WIDTH-1:0]   r_cause;

    logic                   w_idle;
    logic                   w_accept;
    logic                   w_ecall;
    logic                   w_mret;
    logic [CPU_WIDTH-1:0]   w_intr_cause;
    logic [CPU_WIDTH-1:0]   w_mstatus;
    logic [CPU_WIDTH-1:0]   w_base;
    logic [CPU_WIDTH-1:0]   w_vec_off;
    logic                   w_vectored;
    logic [CPU_WIDTH-1:0]   w_target;

    // Priority in IDLE: interrupt, then ecall, then mret.
    assign w_idle       = (r_state == S_IDLE);
    assign w_accept     = w_idle & i_intr_pend & i_wbu_valid & ~i_wbu_nop;
    assign w_ecall      = w_idle & ~w_accept & i_wbu_commit & i_wbu_ecall;
    assign w_mret       = w_idle & ~w_accept & ~w_ecall & i_wbu_commit & i_wbu_mret;
    assign w_intr_cause = {1'b1, {(CPU_WIDTH-5){1'b0}}, i_intr_code};
    assign o_iru_intr   = w_accept;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_ret   <= 1'b0;
            r_epc   <= '0;
            r_cause <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_epc   <= i_wbu_pc;
                        r_cause <= w_intr_cause;
                        r_ret   <= 1'b0;
                        r_state <= S_W_MEPC;
                    end else if (w_ecall) begin
                        r_epc   <= i_wbu_pc;
                        r_cause <= C_CAUSE_ECALL;
                        r_ret   <= 1'b0;
                        r_state <= S_W_MEPC;
                    end else if (w_mret) begin
                        r_ret   <= 1'b1;
                        r_state <= S_W_MSTATUS;
                    end
                end
                S_W_MEPC:    r_state <= S_W_MCAUSE;
                S_W_MCAUSE:  r_state <= S_W_MSTATUS;
                S_W_MSTATUS: r_state <= S_REDIRECT;
                S_REDIRECT:  r_state <= S_IDLE;
                default:     r_state <= S_IDLE;
            endcase
        end
    end

    // mstatus update: MIE is bit 3, MPIE bit 7, MPP bits 12:11.
    always_comb begin
        w_mstatus        = i_csr_mstatus;
        w_mstatus[12:11] = 2'b11;
        if (r_ret) begin
            w_mstatus[3] = i_csr_mstatus[7];
            w_mstatus[7] = 1'b1;
        end else begin
            w_mstatus[7] = i_csr_mstatus[3];
            w_mstatus[3] = 1'b0;
        end
    end

    // Vectored mode applies only to interrupts; the cause MSB marks those.
    assign w_base     = {i_csr_mtvec[CPU_WIDTH-1:2], 2'b00};
    assign w_vec_off  = {{(CPU_WIDTH-6){1'b0}}, r_cause[3:0], 2'b00};
    assign w_vectored = (i_csr_mtvec[1:0] == 2'b01) & r_cause[CPU_WIDTH-1];
    assign w_target   = r_ret      ? i_csr_mepc :
                        w_vectored ? (w_base + w_vec_off) : w_base;

    assign o_redirect_valid = (r_state == S_REDIRECT);
    assign o_redirect_pc    = o_redirect_valid ? w_target : '0;
    assign o_flush          = ~w_idle;
    assign o_busy           = ~w_idle;

    // Shared CSR port: WBU owns it in IDLE, the sequencer owns it otherwise.
    always_comb begin
        o_csr_wen   = 1'b0;
        o_csr_waddr = '0;
        o_csr_wdata = '0;
        case (r_state)
            S_IDLE: begin
                o_csr_wen   = i_wbu_csrdwen;
                o_csr_waddr = i_wbu_csrdid;
                o_csr_wdata = i_wbu_csrd;
            end
            S_W_MEPC: begin
                o_csr_wen   = 1'b1;
                o_csr_waddr = C_ADDR_MEPC;
                o_csr_wdata = r_epc;
            end
            S_W_MCAUSE: begin
                o_csr_wen   = 1'b1;
                o_csr_waddr = C_ADDR_MCAUSE;
                o_csr_wdata = r_cause;
            end
            S_W_MSTATUS: begin
                o_csr_wen   = 1'b1;
                o_csr_waddr = C_ADDR_MSTATUS;
                o_csr_wdata = w_mstatus;
            end
            default: begin
                o_csr_wen   = 1'b0;
                o_csr_waddr = '0;
                o_csr_wdata = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer sitting after the write-back stage: it detects committed `ecall`/`mret` and accepts pending interrupts at the instruction held in WBU. It then flushes the pipeline and writes mepc/mcause/mstatus through the single CSR write port, which it shares with WBU's normal CSR writes. Finally it issues one PC redirect to the fetch stage. One trap or return is in flight at a time.

## Interface
- `CPU_WIDTH`, 64, data/PC width
- `CSR_ADDRW`, 12, CSR address width
- `i_clk`  in  1  clock, rising edge
- `i_rst`  in  1  reset, asynchronous, active-high
- `i_wbu_valid`  in  1  WBU holds an instruction (WBU post-stage valid)
- `i_wbu_commit`  in  1  WBU instruction retires this cycle
- `i_wbu_pc`  in  CPU_WIDTH  PC of WBU instruction
- `i_wbu_ecall` / `i_wbu_mret` / `i_wbu_nop`  in  1 each  WBU instruction type flags
- `i_wbu_csrdwen`  in  1  WBU CSR write request
- `i_wbu_csrdid`  in  CSR_ADDRW  WBU CSR write address
- `i_wbu_csrd`  in  CPU_WIDTH  WBU CSR write data
- `i_intr_pend`  in  1  interrupt pending, already gated by mstatus.MIE/mie
- `i_intr_code`  in  4  interrupt cause code (7 timer, 11 external)
- `i_csr_mstatus` / `i_csr_mtvec` / `i_csr_mepc`  in  CPU_WIDTH each  current CSR values
- `o_iru_intr`  out  1  interrupt accepted; WBU suppresses commit (comb)
- `o_flush`  out  1  flush all pipeline registers
- `o_busy`  out  1  sequence in progress (state != IDLE)
- `o_redirect_valid`  out  1  one-cycle fetch redirect
- `o_redirect_pc`  out  CPU_WIDTH  redirect target
- `o_csr_wen`  out  1  CSR write port enable
- `o_csr_waddr`  out  CSR_ADDRW  CSR write address
- `o_csr_wdata`  out  CPU_WIDTH  CSR write data

## Operation
- States: IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, REDIRECT. Latched kind: TRAP or RET.
- Interrupt accept (comb, IDLE only): `o_iru_intr = i_intr_pend & i_wbu_valid & !i_wbu_nop`.
  - Latch epc=`i_wbu_pc`, cause={1'b1, 59'b0, i_intr_code}, kind=TRAP.
  - Next state W_MEPC.
- Ecall (IDLE, no interrupt accept, `i_wbu_commit & i_wbu_ecall`):
  - Latch epc=`i_wbu_pc`, cause=64'd11, kind=TRAP.
  - Next state W_MEPC.
- Mret (IDLE, no accept, `i_wbu_commit & i_wbu_mret`): kind=RET, next state W_MSTATUS.
- Priority in IDLE: interrupt > ecall > mret. An interrupt arriving on an ecall/mret cycle wins and sets mepc to that instruction's PC.
- W_MEPC writes 0x341 ← epc. Next W_MCAUSE.
- W_MCAUSE writes 0x342 ← cause. Next W_MSTATUS.
- W_MSTATUS writes 0x300 ← `i_csr_mstatus` modified, then next REDIRECT:
  - TRAP: MPIE(7)←MIE(3), MIE←0, MPP(12:11)←2'b11.
  - RET: MIE←MPIE, MPIE←1, MPP←2'b11.
- REDIRECT: `o_redirect_valid`=1, then IDLE. Target:
  - RET: `i_csr_mepc`.
  - TRAP, mtvec[1:0]==1 and interrupt: {mtvec[63:2],2'b0} + 4·code.
  - Otherwise: {mtvec[63:2],2'b0}.
- CSR port mux:
  - IDLE: passes WBU write (`o_csr_wen = i_wbu_csrdwen`, addr/data through).
  - Non-IDLE: WBU requests ignored; port driven only in W_* states.
- `o_flush` = 1 in every non-IDLE state; `o_busy` likewise.

## Timing
- Reset: state IDLE, latches 0, all registered outputs 0. Reset mid-sequence abandons it, with no partial redirect.
- Event seen in IDLE at cycle T. Trap: T+1 W_MEPC, T+2 W_MCAUSE, T+3 W_MSTATUS, T+4 REDIRECT, T+5 IDLE. Mret: T+1 W_MSTATUS, T+2 REDIRECT, T+3 IDLE.
- `o_iru_intr` is combinational in cycle T. The WBU instruction does not retire and its rd/CSR writes are dropped.
- A committing ecall/mret's own WBU CSR write at T passes through; a committing ecall/mret is a retired instruction.
- `o_csr_*` and `o_redirect_*` are combinational from state. CSR values are sampled in the cycle they are used; `i_csr_mepc` is read in REDIRECT, after any software write.
- Events and `i_intr_pend` are ignored while busy. The next accept is possible from T+5 (trap) or T+3 (mret).
- Cause constant is 64-bit; vector offset is computed as `{code,2'b00}` zero-extended, and addition wraps modulo 2^64.

## Test plan
- Reset asserted mid-W_MCAUSE → next edge: IDLE, `o_flush`=0, `o_csr_wen`=0, no redirect; a new ecall then runs the full 4-step sequence.
- Committed ecall at pc 0x8000_0010, mtvec 0x8000_1000, mstatus MIE=1 → writes in order: 0x341←0x8000_0010, 0x342←11, 0x300 with MIE=0/MPIE=1/MPP=3; redirect 0x8000_1000 at T+4; flush T+1..T+4.
- Timer interrupt (code 7), mtvec 0x8000_1001 (vectored), WBU valid pc 0x8000_0200 → `o_iru_intr`=1 at T; mcause 0x8000_0000_0000_0007; redirect 0x8000_101C.
- Interrupt and committing ecall in the same cycle → interrupt path taken; mepc = ecall PC; single sequence only.
- Mret with mepc 0x8000_0014, MPIE=1 → T+1 mstatus MIE=1/MPIE=1; T+2 redirect 0x8000_0014.
- WBU CSR write (0x305←0x1234) in IDLE → passes through same cycle; same request while busy → `o_csr_wen` shows only trap writes; `i_wbu_nop`=1 with interrupt pending → no accept.
